// File: rtl/snake_logic_if.sv
// PRNG food-position handshake between the snake datapath and the PRNG.
// Four-phase req/ack; rand_val is valid while rand_ack is high.
interface snake_logic_if;
  logic       rand_req;
  logic [5:0] rand_val;
  logic       rand_ack;

  modport master (
    output rand_req,
    input  rand_val,
    input  rand_ack
  );

  modport slave (
    input  rand_req,
    output rand_val,
    output rand_ack
  );
endinterface

// File: rtl/snake_logic.sv
// Snake game-board datapath: moves, grows, detects self-collision and
// places food from a PRNG; drives the 8x8 LED occupancy image.
module snake_logic #(
  parameter int          INIT_LEN  = 3,
  parameter logic [5:0]  INIT_HEAD = 6'd27,
  parameter logic [5:0]  INIT_FOOD = 6'd30,
  parameter int          RETRY_MAX = 4
) (
  input  logic          clka,
  input  logic          restart_n,
  input  logic [1:0]    to_logic,
  input  logic [1:0]    direction_state,
  snake_logic_if.master prng,
  output logic [1:0]    from_logic,
  output logic [63:0]   led_array_flat,
  output logic [6:0]    snake_len
);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_COMMIT, S_FOOD_REQ,
    S_FOOD_WAIT, S_SCAN, S_BLINK, S_DONE
  } state_t;

  function automatic logic [5:0] init_cell(input int i);
    logic [2:0] c;
    c = INIT_HEAD[2:0] - 3'(INIT_LEN - 1 - i);
    return {INIT_HEAD[5:3], c};
  endfunction

  function automatic logic [63:0] init_occ();
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < INIT_LEN; i++) m[init_cell(i)] = 1'b1;
    return m;
  endfunction

  localparam logic [63:0] OCC0 = init_occ();
  localparam logic [63:0] LED0 = OCC0 | (64'd1 << INIT_FOOD);
  localparam logic [7:0]  RMAX = 8'(RETRY_MAX - 1);

  state_t      r_state, w_next;
  logic [5:0]  r_body [64];
  logic [5:0]  r_head_ptr, r_tail_ptr;
  logic [63:0] r_occ, r_led;
  logic [5:0]  r_food, r_nh, r_cand, r_scan, r_scnt;
  logic [1:0]  r_dir;
  logic [6:0]  r_len;
  logic [7:0]  r_retry;
  logic        r_blink, r_tick_d, r_ate, r_done, r_end;

  logic [5:0]  w_hc, w_tc, w_nh;
  logic [2:0]  w_row, w_col;
  logic [63:0] w_hbit, w_tbit, w_img;
  logic        w_ev, w_hit, w_win;

  assign w_ev   = to_logic[0] & ~r_tick_d;
  assign w_hc   = r_body[r_head_ptr];
  assign w_tc   = r_body[r_tail_ptr];
  assign w_nh   = {w_row, w_col};
  assign w_hit  = r_occ[w_nh] & ~((w_nh == w_tc) & (w_nh != r_food));
  assign w_win  = (r_len == 7'd63);
  assign w_hbit = 64'd1 << r_nh;
  assign w_tbit = 64'd1 << w_tc;
  assign w_img  = (r_occ | (64'd1 << r_food))
                & ~(r_blink ? (64'd1 << w_hc) : 64'd0);

  always_comb begin
    w_row = w_hc[5:3];
    w_col = w_hc[2:0];
    unique case (r_dir)
      2'd0: w_row = w_hc[5:3] + 3'd1;
      2'd1: w_row = w_hc[5:3] - 3'd1;
      2'd2: w_col = w_hc[2:0] - 3'd1;
      2'd3: w_col = w_hc[2:0] + 3'd1;
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_ev)
          w_next = (to_logic[1] | r_end) ? S_BLINK : S_MOVE;
      S_MOVE:
        w_next = w_hit ? S_DONE : S_COMMIT;
      S_COMMIT:
        w_next = (r_ate & ~w_win) ? S_FOOD_REQ : S_DONE;
      S_FOOD_REQ:
        if (prng.rand_ack) w_next = S_FOOD_WAIT;
      S_FOOD_WAIT:
        if (!prng.rand_ack) begin
          if (!r_occ[r_cand])       w_next = S_DONE;
          else if (r_retry == RMAX) w_next = S_SCAN;
          else                      w_next = S_FOOD_REQ;
        end
      S_SCAN:
        if (!r_occ[r_scan] || r_scnt == 6'd63) w_next = S_DONE;
      S_BLINK: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      for (int i = 0; i < 64; i++)
        r_body[i] <= (i < INIT_LEN) ? init_cell(i) : 6'd0;
      r_head_ptr <= 6'(INIT_LEN - 1);
      r_tail_ptr <= 6'd0;
      r_occ      <= OCC0;
      r_led      <= LED0;
      r_food     <= INIT_FOOD;
      r_len      <= 7'(INIT_LEN);
      r_nh       <= 6'd0;
      r_cand     <= 6'd0;
      r_scan     <= 6'd0;
      r_scnt     <= 6'd0;
      r_dir      <= 2'd0;
      r_retry    <= 8'd0;
      r_blink    <= 1'b0;
      r_tick_d   <= 1'b0;
      r_ate      <= 1'b0;
      r_done     <= 1'b0;
      r_end      <= 1'b0;
    end else begin
      r_tick_d <= to_logic[0];
      unique case (r_state)
        S_IDLE:
          if (w_ev) begin
            r_done <= 1'b0;
            r_dir  <= direction_state;
          end
        S_MOVE: begin
          r_nh  <= w_nh;
          r_ate <= (w_nh == r_food);
          if (w_hit) r_end <= 1'b1;
        end
        S_COMMIT: begin
          r_body[r_head_ptr + 6'd1] <= r_nh;
          r_head_ptr <= r_head_ptr + 6'd1;
          r_blink    <= 1'b0;
          if (r_ate) begin
            r_occ   <= r_occ | w_hbit;
            r_len   <= r_len + 7'd1;
            r_retry <= 8'd0;
            if (w_win) r_end <= 1'b1;
          end else begin
            // clear before set: a tail-chasing head keeps its bit
            r_occ      <= (r_occ & ~w_tbit) | w_hbit;
            r_tail_ptr <= r_tail_ptr + 6'd1;
          end
        end
        S_FOOD_REQ:
          if (prng.rand_ack) r_cand <= prng.rand_val;
        S_FOOD_WAIT:
          if (!prng.rand_ack) begin
            if (!r_occ[r_cand]) r_food <= r_cand;
            else begin
              r_retry <= r_retry + 8'd1;
              r_scan  <= r_cand;
              r_scnt  <= 6'd0;
            end
          end
        S_SCAN:
          if (!r_occ[r_scan]) r_food <= r_scan;
          else begin
            r_scan <= r_scan + 6'd1;
            r_scnt <= r_scnt + 6'd1;
          end
        S_BLINK: r_blink <= ~r_blink;
        S_DONE: begin
          r_done <= 1'b1;
          r_led  <= w_img;
        end
        default: ;
      endcase
    end
  end

  assign prng.rand_req  = (r_state == S_FOOD_REQ);
  assign from_logic     = {r_end, r_done};
  assign led_array_flat = r_led;
  assign snake_len      = r_len;

endmodule

// File: tb/tb_snake_logic.sv
// Directed bench for snake_logic: scoreboard of expected board states
// per tick, plus an automatic four-phase PRNG responder.
module tb_snake_logic;

  localparam logic [1:0] UP = 2'd0;
  localparam logic [1:0] DN = 2'd1;
  localparam logic [1:0] LF = 2'd2;
  localparam logic [1:0] RT = 2'd3;

  logic        clka = 1'b0;
  logic        restart_n;
  logic [1:0]  to_logic;
  logic [1:0]  direction_state;
  logic [1:0]  from_logic;
  logic [63:0] led_array_flat;
  logic [6:0]  snake_len;

  always #5 clka = ~clka;

  snake_logic_if prng_if ();

  snake_logic dut (
    .clka            (clka),
    .restart_n       (restart_n),
    .to_logic        (to_logic),
    .direction_state (direction_state),
    .prng            (prng_if),
    .from_logic      (from_logic),
    .led_array_flat  (led_array_flat),
    .snake_len       (snake_len)
  );

  typedef struct packed {
    logic [63:0] led;
    logic [1:0]  fl;
    logic [6:0]  len;
    logic [3:0]  lat;
  } exp_t;

  exp_t       sb[$];
  logic [5:0] rq[$];
  int         checks = 0;
  int         errors = 0;
  int         acks   = 0;
  logic       force_ack = 1'b0;

  function automatic logic [63:0] b(input int i);
    return 64'd1 << i;
  endfunction

  function automatic exp_t mk(input logic [63:0] led,
                              input logic [1:0] fl,
                              input logic [6:0] len,
                              input logic [3:0] lat);
    exp_t e;
    e.led = led;
    e.fl  = fl;
    e.len = len;
    e.lat = lat;
    return e;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // PRNG model: answers each request with the next queued value
  initial begin
    prng_if.rand_ack = 1'b0;
    prng_if.rand_val = 6'd0;
    forever begin
      @(negedge clka);
      if (force_ack) prng_if.rand_ack = 1'b1;
      else if (prng_if.rand_req && !prng_if.rand_ack && rq.size() > 0) begin
        prng_if.rand_val = rq.pop_front();
        prng_if.rand_ack = 1'b1;
        acks++;
      end else if (prng_if.rand_ack && !prng_if.rand_req)
        prng_if.rand_ack = 1'b0;
    end
  end

  task automatic do_tick(input logic [1:0] dir, input logic nu,
                         input int hold, input exp_t e);
    exp_t x;
    int   n;
    bit   seen;
    sb.push_back(e);
    @(negedge clka);
    direction_state = dir;
    to_logic = {nu, 1'b1};
    n = -1;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(posedge clka);
      #1;
      n++;
      seen = from_logic[0];
    end
    x = sb.pop_front();
    chk("done_seen", 64'(seen), 64'd1);
    if (x.lat != 0) chk("latency", 64'(n), 64'(x.lat));
    chk("led", led_array_flat, x.led);
    chk("from_logic", 64'(from_logic), 64'(x.fl));
    chk("snake_len", 64'(snake_len), 64'(x.len));
    if (hold > n) begin
      while (n < hold) begin
        @(posedge clka);
        #1;
        n++;
      end
      chk("hold_led", led_array_flat, x.led);
      chk("hold_from", 64'(from_logic), 64'(x.fl));
    end
    @(negedge clka);
    to_logic[0] = 1'b0;
    repeat (2) @(negedge clka);
  endtask

  initial begin
    logic [63:0] l0, fz;
    int a0, n;
    l0 = b(25) | b(26) | b(27) | b(30);
    restart_n = 1'b0;
    to_logic = 2'b00;
    direction_state = UP;
    repeat (3) @(negedge clka);
    chk("rst_led", led_array_flat, l0);
    chk("rst_from", 64'(from_logic), 64'd0);
    chk("rst_len", 64'(snake_len), 64'd3);
    chk("rst_req", 64'(prng_if.rand_req), 64'd0);
    restart_n = 1'b1;
    repeat (2) @(negedge clka);
    chk("idle_led", led_array_flat, l0);

    do_tick(RT, 1'b0, 5, mk(b(26)|b(27)|b(28)|b(30), 2'b01, 7'd3, 4'd3));
    do_tick(RT, 1'b0, 0, mk(b(27)|b(28)|b(29)|b(30), 2'b01, 7'd3, 4'd3));
    do_tick(RT, 1'b1, 0, mk(b(27)|b(28)|b(30), 2'b01, 7'd3, 4'd2));

    a0 = acks;
    rq.push_back(6'd27);
    rq.push_back(6'd0);
    do_tick(RT, 1'b0, 0,
            mk(b(27)|b(28)|b(29)|b(30)|b(0), 2'b01, 7'd4, 4'd0));
    chk("acks_eat1", 64'(acks - a0), 64'd2);

    do_tick(DN, 1'b0, 0, mk(b(28)|b(29)|b(30)|b(22)|b(0), 2'b01, 7'd4, 4'd3));
    do_tick(DN, 1'b0, 0, mk(b(29)|b(30)|b(22)|b(14)|b(0), 2'b01, 7'd4, 4'd3));
    do_tick(DN, 1'b0, 0, mk(b(30)|b(22)|b(14)|b(6)|b(0), 2'b01, 7'd4, 4'd3));
    do_tick(RT, 1'b0, 0, mk(b(22)|b(14)|b(6)|b(7)|b(0), 2'b01, 7'd4, 4'd3));

    a0 = acks;
    rq.push_back(6'd14);
    rq.push_back(6'd0);
    rq.push_back(6'd6);
    rq.push_back(6'd22);
    do_tick(RT, 1'b0, 0,
            mk(b(22)|b(14)|b(6)|b(7)|b(0)|b(23), 2'b01, 7'd5, 4'd0));
    chk("acks_scan", 64'(acks - a0), 64'd4);

    do_tick(UP, 1'b0, 0, mk(b(14)|b(6)|b(7)|b(0)|b(8)|b(23), 2'b01, 7'd5, 4'd3));
    do_tick(UP, 1'b0, 0, mk(b(6)|b(7)|b(0)|b(8)|b(16)|b(23), 2'b01, 7'd5, 4'd3));

    rq.push_back(6'd40);
    do_tick(LF, 1'b0, 0,
            mk(b(6)|b(7)|b(0)|b(8)|b(16)|b(23)|b(40), 2'b01, 7'd6, 4'd0));

    do_tick(UP, 1'b0, 0, mk(b(7)|b(0)|b(8)|b(16)|b(23)|b(31)|b(40), 2'b01, 7'd6, 4'd3));
    do_tick(UP, 1'b0, 0, mk(b(0)|b(8)|b(16)|b(23)|b(31)|b(39)|b(40), 2'b01, 7'd6, 4'd3));
    do_tick(UP, 1'b0, 0, mk(b(8)|b(16)|b(23)|b(31)|b(39)|b(47)|b(40), 2'b01, 7'd6, 4'd3));
    do_tick(UP, 1'b0, 0, mk(b(16)|b(23)|b(31)|b(39)|b(47)|b(55)|b(40), 2'b01, 7'd6, 4'd3));
    do_tick(UP, 1'b0, 0, mk(b(23)|b(31)|b(39)|b(47)|b(55)|b(63)|b(40), 2'b01, 7'd6, 4'd3));
    do_tick(UP, 1'b0, 0, mk(b(31)|b(39)|b(47)|b(55)|b(63)|b(7)|b(40), 2'b01, 7'd6, 4'd3));
    do_tick(UP, 1'b0, 0, mk(b(39)|b(47)|b(55)|b(63)|b(7)|b(15)|b(40), 2'b01, 7'd6, 4'd3));
    do_tick(LF, 1'b0, 0, mk(b(47)|b(55)|b(63)|b(7)|b(15)|b(14)|b(40), 2'b01, 7'd6, 4'd3));
    fz = b(55)|b(63)|b(7)|b(15)|b(14)|b(6)|b(40);
    do_tick(DN, 1'b0, 0, mk(fz, 2'b01, 7'd6, 4'd3));

    do_tick(RT, 1'b0, 0, mk(fz, 2'b11, 7'd6, 4'd2));
    do_tick(RT, 1'b1, 0, mk(fz & ~b(6), 2'b11, 7'd6, 4'd2));
    do_tick(RT, 1'b1, 0, mk(fz, 2'b11, 7'd6, 4'd2));
    do_tick(UP, 1'b0, 0, mk(fz & ~b(6), 2'b11, 7'd6, 4'd2));
    chk("end_req", 64'(prng_if.rand_req), 64'd0);

    @(negedge clka);
    restart_n = 1'b0;
    @(negedge clka);
    restart_n = 1'b1;
    chk("rst2_led", led_array_flat, l0);
    do_tick(RT, 1'b0, 0, mk(b(26)|b(27)|b(28)|b(30), 2'b01, 7'd3, 4'd3));
    do_tick(RT, 1'b0, 0, mk(b(27)|b(28)|b(29)|b(30), 2'b01, 7'd3, 4'd3));
    @(negedge clka);
    direction_state = RT;
    to_logic = 2'b01;
    n = 0;
    while (!prng_if.rand_req && n < 20) begin
      @(posedge clka);
      #1;
      n++;
    end
    chk("req_high", 64'(prng_if.rand_req), 64'd1);
    @(negedge clka);
    to_logic = 2'b00;
    chk("req_held", 64'(prng_if.rand_req), 64'd1);
    restart_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(prng_if.rand_req), 64'd0);
    chk("mid_rst_led", led_array_flat, l0);
    chk("mid_rst_from", 64'(from_logic), 64'd0);
    chk("mid_rst_len", 64'(snake_len), 64'd3);
    @(negedge clka);
    restart_n = 1'b1;
    force_ack = 1'b1;
    repeat (3) @(negedge clka);
    force_ack = 1'b0;
    repeat (2) @(negedge clka);
    chk("late_ack_req", 64'(prng_if.rand_req), 64'd0);
    chk("late_ack_led", led_array_flat, l0);
    chk("late_ack_from", 64'(from_logic), 64'd0);
    do_tick(RT, 1'b0, 0, mk(b(26)|b(27)|b(28)|b(30), 2'b01, 7'd3, 4'd3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
